// File: rtl/ddr_burst_interface_pkg.sv
// Shared definitions for the DDR burst interface: state codes, request kinds
// and default burst lengths.
package ddr_burst_interface_pkg;

  localparam int BURST_LEN_DEFAULT = 16;
  localparam int JMP_BURST_LEN     = 1;

  // The cache decodes MEM_WRITE_DATA_STORE (9) to qualify its store beats.
  typedef enum logic [3:0] {
    MEM_IDLE             = 4'd0,
    MEM_READ_DATA        = 4'd1,
    MEM_READ_JMP         = 4'd2,
    MEM_WRITE_DATA_STORE = 4'd9,
    MEM_DONE             = 4'd10
  } mem_state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_STORE = 2'd1,
    REQ_READ  = 2'd2,
    REQ_JMP   = 2'd3
  } req_kind_e;

endpackage

// File: rtl/ddr_burst_interface_rd_beat_capture.sv
// Read-return register slice: registers each returned beat together with its
// 1-based beat index, and captures the zero-extended jump address.
module rd_beat_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 28,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic                  beat_jmp,
  input  logic [DATA_WIDTH-1:0] beat_data,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] jmp_addr
);

  // Count and data hold between beats; the count is cleared only at read start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_cnt   <= '0;
      rd_data  <= '0;
      jmp_addr <= '0;
    end else begin
      rd_valid <= beat_valid;
      if (clear)
        rd_cnt <= '0;
      else if (beat_valid)
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      if (beat_valid)
        rd_data <= beat_data;
      if (beat_valid && beat_jmp)
        jmp_addr <= ADDR_WIDTH'(beat_data);
    end
  end

endmodule

// File: rtl/ddr_burst_interface.sv
// Arbitrates the data cache's store, data-load and jump-load requests and turns
// each into one burst on the native DDR controller port.
module ddr_burst_interface
  import ddr_burst_interface_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BURST_LEN      = BURST_LEN_DEFAULT,
  parameter int CNT_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req,
  input  logic                      DATA_store_req,
  input  logic                      JMP_ADDR_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  input  logic                      data_to_ddr_rdy,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic [CNT_WIDTH-1:0]      rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      mem_rd_req,
  output logic [CNT_WIDTH-1:0]      mem_rd_len,
  output logic [DDR_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  input  logic                      mem_rd_valid,
  input  logic                      mem_rd_finish,
  output logic                      mem_wr_req,
  output logic [CNT_WIDTH-1:0]      mem_wr_len,
  output logic [DDR_ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic                      mem_wr_data_req,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic                      mem_wr_finish
);

  mem_state_e state, state_nxt;
  req_kind_e  svc_kind, svc_nxt;
  logic       svc_pending;
  logic       in_read, in_store, start_rd, start_wr, rd_beat, wr_beat;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic       wr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MEM_IDLE;
      svc_kind <= REQ_NONE;
    end else begin
      state    <= state_nxt;
      svc_kind <= svc_nxt;
    end
  end

  // MEM_DONE waits on whichever level request was serviced, so a request that
  // is still high cannot restart the same burst.
  always_comb begin
    svc_pending = 1'b0;
    case (svc_kind)
      REQ_STORE: svc_pending = DATA_store_req;
      REQ_READ:  svc_pending = DATA_read_req;
      REQ_JMP:   svc_pending = JMP_ADDR_read_req;
      default:   svc_pending = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    svc_nxt   = svc_kind;
    case (state)
      MEM_IDLE: begin
        if (DATA_store_req) begin
          state_nxt = MEM_WRITE_DATA_STORE;
          svc_nxt   = REQ_STORE;
        end else if (DATA_read_req) begin
          state_nxt = MEM_READ_DATA;
          svc_nxt   = REQ_READ;
        end else if (JMP_ADDR_read_req) begin
          state_nxt = MEM_READ_JMP;
          svc_nxt   = REQ_JMP;
        end
      end
      MEM_READ_DATA, MEM_READ_JMP: begin
        if (mem_rd_finish)
          state_nxt = MEM_DONE;
      end
      MEM_WRITE_DATA_STORE: begin
        if (mem_wr_finish)
          state_nxt = MEM_DONE;
      end
      MEM_DONE: begin
        if (!svc_pending) begin
          state_nxt = MEM_IDLE;
          svc_nxt   = REQ_NONE;
        end
      end
      default: begin
        state_nxt = MEM_IDLE;
        svc_nxt   = REQ_NONE;
      end
    endcase
  end

  assign in_read  = (state == MEM_READ_DATA) || (state == MEM_READ_JMP);
  assign in_store = (state == MEM_WRITE_DATA_STORE);
  assign start_rd = (state == MEM_IDLE) &&
                    ((state_nxt == MEM_READ_DATA) || (state_nxt == MEM_READ_JMP));
  assign start_wr = (state == MEM_IDLE) && (state_nxt == MEM_WRITE_DATA_STORE);
  assign rd_beat  = in_read && mem_rd_valid;
  assign wr_beat  = in_store && mem_wr_data_req;

  // Read burst command: address and length latched at start, request dropped
  // once the controller returns its first beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_req  <= 1'b0;
      mem_rd_len  <= '0;
      mem_rd_addr <= '0;
    end else if (start_rd) begin
      mem_rd_req  <= 1'b1;
      mem_rd_addr <= DATA_read_addr;
      mem_rd_len  <= (state_nxt == MEM_READ_JMP) ? CNT_WIDTH'(JMP_BURST_LEN)
                                                 : CNT_WIDTH'(BURST_LEN);
    end else if (in_read && (mem_rd_valid || mem_rd_finish)) begin
      mem_rd_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wr_req  <= 1'b0;
      mem_wr_len  <= '0;
      mem_wr_addr <= '0;
    end else if (start_wr) begin
      mem_wr_req  <= 1'b1;
      mem_wr_addr <= DATA_write_addr;
      mem_wr_len  <= CNT_WIDTH'(BURST_LEN);
    end else if (in_store && (mem_wr_data_req || mem_wr_finish)) begin
      mem_wr_req  <= 1'b0;
    end
  end

  // The error flag records any beat pulled while the cache had no data ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      wr_err <= 1'b0;
    end else begin
      if (start_wr)
        wr_cnt <= '0;
      else if (wr_beat)
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      if (wr_beat && !data_to_ddr_rdy)
        wr_err <= 1'b1;
    end
  end

  assign wr_burst_data_req      = wr_beat;
  assign mem_wr_data            = (in_store && data_to_ddr_rdy) ? DATA_to_ddr : '0;
  assign state_interface_module = state;

  rd_beat_capture #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DDR_ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_rd_beat_capture (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_rd),
    .beat_valid (rd_beat),
    .beat_jmp   (state == MEM_READ_JMP),
    .beat_data  (mem_rd_data),
    .rd_valid   (rd_burst_data_valid),
    .rd_cnt     (rd_cnt_data),
    .rd_data    (DATA_to_cache),
    .jmp_addr   (JMP_ADDR_to_cache)
  );

endmodule

// File: doc/ddr_burst_interface.md
Name: ddr_burst_interface

Overview:
- Memory-side stage directly downstream of the data cache.
- Arbitrates the cache's three DDR requests: data burst load, data burst store, jump-address load. Converts each into one burst on a simple native burst port toward the DDR controller.
- Returns read beats with a beat counter and valid strobe, and paces store data with a per-beat request.
- Exposes its state code so the cache can qualify store beats.

Parameters:
- DATA_WIDTH, 16, beat width on both the cache side and the memory side.
- DDR_ADDR_WIDTH, 28, DDR byte address width.
- BURST_LEN, 16, beats per data load/store burst; equals the cache depth.
- CNT_WIDTH, 10, width of beat counters and burst length fields.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- DATA_read_req  in  1  level request: load BURST_LEN beats
- DATA_store_req  in  1  level request: store BURST_LEN beats
- JMP_ADDR_read_req  in  1  level request: load 1 beat as jump address
- DATA_read_addr  in  DDR_ADDR_WIDTH  load/jump start address
- DATA_write_addr  in  DDR_ADDR_WIDTH  store start address
- DATA_to_ddr  in  DATA_WIDTH  store beat from cache
- data_to_ddr_rdy  in  1  cache is presenting store data
- DATA_to_cache  out  DATA_WIDTH  registered read beat
- JMP_ADDR_to_cache  out  DDR_ADDR_WIDTH  zero-extended jump beat
- rd_cnt_data  out  CNT_WIDTH  index of current read beat (1-based)
- rd_burst_data_valid  out  1  read beat valid
- wr_burst_data_req  out  1  memory wants a store beat
- state_interface_module  out  4  current state code
- mem_rd_req  out  1  memory read burst request
- mem_rd_len  out  CNT_WIDTH  read burst length
- mem_rd_addr  out  DDR_ADDR_WIDTH  read burst address
- mem_rd_data  in  DATA_WIDTH  read beat
- mem_rd_valid  in  1  read beat valid
- mem_rd_finish  in  1  read burst complete pulse
- mem_wr_req  out  1  memory write burst request
- mem_wr_len  out  CNT_WIDTH  write burst length
- mem_wr_addr  out  DDR_ADDR_WIDTH  write burst address
- mem_wr_data_req  in  1  memory pulls a write beat this cycle
- mem_wr_data  out  DATA_WIDTH  write beat
- mem_wr_finish  in  1  write burst complete pulse

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk. All outputs and registers are clocked on clk.
- Reset value of every output is 0. State resets to MEM_IDLE. Reset mid-burst drops mem_rd_req/mem_wr_req immediately; the controller must also be reset.
- State codes:
  - MEM_IDLE = 0
  - MEM_READ_DATA = 1
  - MEM_READ_JMP = 2
  - MEM_WRITE_DATA_STORE = 9 (the cache decodes this value)
  - MEM_DONE = 10
- MEM_IDLE:
  - Fixed priority: store > data read > jump read.
  - Latch the address and length on entry: BURST_LEN for data, 1 for jump.
  - Clear rd_cnt_data on entry to a read state.
- MEM_READ_*:
  - mem_rd_req is held high until the first mem_rd_valid, then low.
  - For each mem_rd_valid beat k (k = 1..len), the next cycle shows rd_burst_data_valid = 1, rd_cnt_data = k and DATA_to_cache = beat. Latency is 1 cycle.
  - rd_cnt_data holds its last value between beats and after the burst. It is cleared only on the next read start.
  - In MEM_READ_JMP, JMP_ADDR_to_cache = {zeros, beat} is registered in the same cycle as DATA_to_cache. It holds until the next jump read.
  - mem_rd_finish -> MEM_DONE.
- MEM_WRITE_DATA_STORE:
  - mem_wr_req is held until the first mem_wr_data_req.
  - wr_burst_data_req = mem_wr_data_req (combinational, this state only).
  - mem_wr_data = DATA_to_ddr (combinational).
  - An internal beat counter increments on each mem_wr_data_req.
  - mem_wr_finish -> MEM_DONE.
  - If mem_wr_data_req arrives while data_to_ddr_rdy = 0, send 0 and set a sticky error flag, observable internally and cleared by reset.
- MEM_DONE:
  - Wait until the serviced request is deasserted, then return to MEM_IDLE.
  - This prevents a still-high level request from restarting the same burst.
- Request dropped mid-burst: the burst always runs to finish. Read beats are still presented; extra write beats carry DATA_to_ddr.
- Simultaneous store and read requests: the store is served first; the read is served after MEM_DONE.
- Address arithmetic: addresses pass through unmodified; no wrap handling.
- Lengths are constant for the duration of a burst.

Decomposition:
- Shared package:
  - state codes, including MEM_WRITE_DATA_STORE = 4'd9
  - BURST_LEN default
  - jump burst length 1
- No sub-module is needed. An optional read-return register slice, rd_beat_capture, holds the valid, count and data registers.

Test Plan:
- Data load: DATA_read_req = 1, addr 0x28000. Controller returns 16 beats 0x1000..0x100F. Required: mem_rd_addr = 0x28000 and mem_rd_len = 16; rd_cnt_data steps 1..16 one cycle after each beat; DATA_to_cache matches; state goes 1 -> 10 -> 0 once the request drops.
- Jump load: JMP_ADDR_read_req = 1, beat 0x0ABC. Required: mem_rd_len = 1; one cycle after the beat, rd_cnt_data = 1, rd_burst_data_valid = 1, JMP_ADDR_to_cache = 0x0000ABC.
- Store: DATA_store_req = 1, addr 0x40000, cache drives 0xA0..0xAF with data_to_ddr_rdy = 1. Controller pulls 16 beats with gaps. Required: wr_burst_data_req mirrors mem_wr_data_req only while state = 9; mem_wr_data sequence matches; error flag stays 0.
- Priority: assert all three requests together. Required: store runs first, then data read, then jump; each returns to IDLE only after its request drops.
- Level hold: keep DATA_read_req high after mem_rd_finish for 5 cycles. Required: state stays 10 and no second mem_rd_req until the request drops.
- Reset mid-store at beat 7. Required: all outputs 0 and state 0 in the same cycle; a fresh store afterwards completes 16 beats.
